// File: rtl/pixel_stream_source.sv
// Pixel-stream playback source: reads a stored frame from a synchronous RAM in raster
// order and emits it on en/hsync/vsync/data with programmable H/V blanking.
// Latency: read issued in cycle t appears on en/data in cycle t+2. No backpressure.
module pixel_stream_source #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int HBLANK       = 16,
  parameter int VBLANK       = 1000,
  parameter int ADDR_WIDTH   = 19,
  parameter int PIXEL_SIZE   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int XW   = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(HBLANK - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(VBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;

  // Flags generated alongside the read, then carried down the pipeline with it.
  logic                    rd_hs, rd_vs, rd_fd;

  // Stage 1: read in flight (RAM latency).
  logic                    s1_vld, s1_hs, s1_vs, s1_fd;

  // Raster scan state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state logic: read strobe, raster counters, blanking countdown.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    rd_en   = 1'b0;
    rd_hs   = 1'b0;
    rd_vs   = 1'b0;
    rd_fd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      S_ACTIVE: begin
        rd_en  = 1'b1;
        rd_hs  = (x_q == '0);
        rd_vs  = (x_q == '0) && (y_q == '0);
        rd_fd  = (x_q == X_LAST) && (y_q == Y_LAST);
        addr_d = addr_q + 1'b1;
        if (x_q == X_LAST) begin
          x_d     = '0;
          bcnt_d  = '0;
          state_d = (y_q == Y_LAST) ? S_VBLANK : S_HBLANK;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_HBLANK: begin
        // Address is left alone so the next line continues sequentially.
        if (bcnt_q == HB_LAST) begin
          bcnt_d  = '0;
          y_d     = y_q + 1'b1;
          state_d = S_ACTIVE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_VBLANK: begin
        // continuous is only looked at here, so mid-frame changes wait for this point.
        if (bcnt_q == VB_LAST) begin
          bcnt_d  = '0;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          state_d = continuous ? S_ACTIVE : S_IDLE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr = addr_q;

  // Stage 1: track which cycle's RAM output carries a real pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_fd  <= 1'b0;
    end else begin
      s1_vld <= rd_en;
      s1_hs  <= rd_hs;
      s1_vs  <= rd_vs;
      s1_fd  <= rd_fd;
    end
  end

  // Stage 2: output register; data forced to zero on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
      data       <= '0;
    end else begin
      en         <= s1_vld;
      hsync      <= s1_vld & s1_hs;
      vsync      <= s1_vld & s1_vs;
      frame_done <= s1_vld & s1_fd;
      data       <= s1_vld ? rd_data : '0;
    end
  end

  // Busy covers the scan itself plus any pixel still travelling to the outputs.
  assign busy = (state_q != S_IDLE) | s1_vld | en;

endmodule
